// File: rtl/picorv32_mem_responder.sv
// picorv32_mem_responder
//   Sole bus target for the PicoRV32 native memory interface. It serves fetches,
//   loads and stores from an on-chip word RAM after a fixed number of wait states.
//   It also decodes two write-only MMIO registers: a console byte port and a
//   test-exit port.
// Ports
//   clk, resetn            clock (rising edge), asynchronous active-low reset
//   mem_valid/mem_instr    core request; a fetch is handled exactly like a read
//   mem_addr/wdata/wstrb   byte address (bits [1:0] ignored), store data, lane enables
//   mem_ready/mem_rdata    one-cycle completion pulse and its read data
//   console_valid/data     one-cycle pulse carrying a console byte
//   exit_valid/exit_code   sticky test-exit flag and the value written to it
//   bus_error              sticky: unmapped access or handshake violation
module picorv32_mem_responder #(
    parameter int          MEM_WORDS    = 16384,
    parameter int          WAIT_CYCLES  = 1,
    parameter logic [31:0] CONSOLE_ADDR = 32'h1000_0000,
    parameter logic [31:0] EXIT_ADDR    = 32'h2000_0000,
    parameter logic [31:0] ERR_RDATA    = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic        mem_instr,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        console_valid,
    output logic [7:0]  console_data,
    output logic        exit_valid,
    output logic [31:0] exit_code,
    output logic        bus_error
);

    localparam int          IDX_W       = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [29:0] MEM_WORDS_W = 30'(MEM_WORDS);
    localparam logic [3:0]  WAIT_LOAD   = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam bit          HAS_WAIT    = (WAIT_CYCLES > 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t           state_r;
    state_t           next_state_s;
    logic [3:0]       cnt_r;
    logic [31:0]      addr_r;
    logic [31:0]      wdata_r;
    logic [3:0]       wstrb_r;
    logic [31:0]      ram_r [0:MEM_WORDS-1];

    logic [31:0]      txn_addr_s;
    logic [31:0]      txn_wdata_s;
    logic [3:0]       txn_wstrb_s;
    logic             hit_console_s;
    logic             hit_exit_s;
    logic             hit_ram_s;
    logic             unmapped_s;
    logic             is_write_s;
    logic [IDX_W-1:0] ram_idx_s;
    logic             enter_resp_s;
    logic             violation_s;
    logic             console_fire_s;
    logic             unused_s;

    // Fetch flag and byte offset carry no information for a word-wide target.
    assign unused_s = ^{mem_instr, txn_addr_s[1:0]};

    // Transaction view: live bus in IDLE (zero-wait case commits straight from IDLE), captured copy otherwise.
    always_comb begin
        txn_addr_s  = addr_r;
        txn_wdata_s = wdata_r;
        txn_wstrb_s = wstrb_r;
        if (state_r == ST_IDLE) begin
            txn_addr_s  = mem_addr;
            txn_wdata_s = mem_wdata;
            txn_wstrb_s = mem_wstrb;
        end else begin
            txn_addr_s  = addr_r;
            txn_wdata_s = wdata_r;
            txn_wstrb_s = wstrb_r;
        end
    end

    // Address decode; MMIO registers shadow any RAM alias.
    always_comb begin
        hit_console_s  = (txn_addr_s[31:2] == CONSOLE_ADDR[31:2]);
        hit_exit_s     = (txn_addr_s[31:2] == EXIT_ADDR[31:2]);
        hit_ram_s      = !hit_console_s && !hit_exit_s && (txn_addr_s[31:2] < MEM_WORDS_W);
        unmapped_s     = !hit_console_s && !hit_exit_s && !hit_ram_s;
        is_write_s     = (txn_wstrb_s != 4'b0000);
        ram_idx_s      = txn_addr_s[IDX_W+1:2];
        enter_resp_s   = (next_state_s == ST_RESP) && (state_r != ST_RESP);
        console_fire_s = enter_resp_s && is_write_s && hit_console_s && txn_wstrb_s[0];
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (mem_valid) begin
                    if (HAS_WAIT) begin
                        next_state_s = ST_WAIT;
                    end else begin
                        next_state_s = ST_RESP;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = ST_RESP;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // The core must hold its request stable until it has seen mem_ready.
    always_comb begin
        violation_s = 1'b0;
        if (state_r == ST_WAIT) begin
            violation_s = !mem_valid || (mem_addr != addr_r) ||
                          (mem_wdata != wdata_r) || (mem_wstrb != wstrb_r);
        end else if (state_r == ST_RESP) begin
            violation_s = !mem_valid;
        end else begin
            violation_s = 1'b0;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Request capture and wait-state counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_r  <= 32'd0;
            wdata_r <= 32'd0;
            wstrb_r <= 4'd0;
            cnt_r   <= 4'd0;
        end else if (state_r == ST_IDLE && mem_valid) begin
            addr_r  <= mem_addr;
            wdata_r <= mem_wdata;
            wstrb_r <= mem_wstrb;
            cnt_r   <= WAIT_LOAD;
        end else if (state_r == ST_WAIT && cnt_r != 4'd0) begin
            cnt_r <= cnt_r - 4'd1;
        end
    end

    // Registered bus response, MMIO side effects and sticky status.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready     <= 1'b0;
            mem_rdata     <= 32'd0;
            console_valid <= 1'b0;
            console_data  <= 8'd0;
            exit_valid    <= 1'b0;
            exit_code     <= 32'd0;
            bus_error     <= 1'b0;
        end else begin
            mem_ready     <= enter_resp_s;
            console_valid <= console_fire_s;
            if (console_fire_s) begin
                console_data <= txn_wdata_s[7:0];
            end
            if (enter_resp_s && !is_write_s) begin
                if (hit_ram_s) begin
                    mem_rdata <= ram_r[ram_idx_s];
                end else if (unmapped_s) begin
                    mem_rdata <= ERR_RDATA;
                end else begin
                    mem_rdata <= 32'd0;
                end
            end else begin
                mem_rdata <= 32'd0;
            end
            if (enter_resp_s && is_write_s && hit_exit_s) begin
                exit_valid <= 1'b1;
                exit_code  <= txn_wdata_s;
            end
            if (violation_s || (enter_resp_s && unmapped_s)) begin
                bus_error <= 1'b1;
            end
        end
    end

    // Byte-lane RAM write; the array has no reset, and resetn gates out any commit while it is low.
    always_ff @(posedge clk) begin
        if (resetn && enter_resp_s && is_write_s && hit_ram_s) begin
            for (int i = 0; i < 4; i++) begin
                if (txn_wstrb_s[i]) begin
                    ram_r[ram_idx_s][8*i +: 8] <= txn_wdata_s[8*i +: 8];
                end
            end
        end
    end

endmodule
